// File: rtl/infix_to_postfix.sv
`default_nettype none
// ============================================================================
// Module      : infix_to_postfix
// Description : Shunting-yard converter. Reads a tokenised infix array and
//               writes the postfix array plus its size, one stack action per
//               clock, using a DEPTH-entry operator stack.
//               Token format: [NEW_WIDTH-1:NEW_WIDTH-2] == 2'b00 is a constant,
//               anything else is an operator whose code sits in [7:0].
// Ports       : clock       - system clock (posedge)
//               reset       - synchronous, active-high
//               conv        - start request, rising edge accepted when idle
//               infixSize   - number of valid infix tokens
//               infix       - infix tokens, index 0 first, stable while busy
//               postfixSize - number of valid postfix tokens
//               postfix     - postfix tokens (registered)
//               busy        - high from start until the done/error edge
//               done        - 1-cycle pulse on successful conversion
//               error       - 1-cycle pulse on failed conversion
// Revision    : 1.0 - initial release
// ============================================================================
module infix_to_postfix #(
    parameter int DEPTH     = 10,
    parameter int NEW_WIDTH = 44
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  conv,
    input  logic [$clog2(DEPTH+1)-1:0]            infixSize,
    input  logic [DEPTH-1:0][NEW_WIDTH-1:0]       infix,
    output logic [$clog2(DEPTH+1)-1:0]            postfixSize,
    output logic [DEPTH-1:0][NEW_WIDTH-1:0]       postfix,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error
);

    localparam int SW = $clog2(DEPTH + 1);

    localparam logic [SW-1:0] c_DEPTH  = SW'(DEPTH);
    localparam logic [7:0]    c_LPAREN = 8'h28;
    localparam logic [7:0]    c_RPAREN = 8'h29;
    localparam logic [7:0]    c_ADD    = 8'h2A;
    localparam logic [7:0]    c_SUB    = 8'h2B;
    localparam logic [7:0]    c_MUL    = 8'h2C;
    localparam logic [7:0]    c_DIV    = 8'h2D;
    localparam logic [7:0]    c_COMMA  = 8'h2E;
    localparam logic [7:0]    c_FN_LO  = 8'hF0;
    localparam logic [7:0]    c_FN_HI  = 8'hF6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_CLOSE = 3'd2,   // after a '(' discard: pop a waiting function, then advance
        S_FLUSH = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                          r_state;
    logic [SW-1:0]                   r_i;
    logic [SW-1:0]                   r_o;
    logic [SW-1:0]                   r_sp;
    logic [NEW_WIDTH-1:0]            r_stack [DEPTH];
    logic [DEPTH-1:0][NEW_WIDTH-1:0] r_postfix;
    logic [SW-1:0]                   r_postfix_size;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_error;
    logic                            r_conv_prev;

    // ------------------------------------------------------------------
    // Token classification helpers
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_prec(input logic [NEW_WIDTH-1:0] t);
        logic [1:0] p;
        p = 2'd0;
        if (t[NEW_WIDTH-1 -: 2] != 2'b00) begin
            if (t[7:0] == c_ADD || t[7:0] == c_SUB) p = 2'd1;
            if (t[7:0] == c_MUL || t[7:0] == c_DIV) p = 2'd2;
        end
        return p;
    endfunction

    function automatic logic f_is_func(input logic [NEW_WIDTH-1:0] t);
        return (t[NEW_WIDTH-1 -: 2] != 2'b00) && (t[7:0] >= c_FN_LO) && (t[7:0] <= c_FN_HI);
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle decode of the stack action
    // ------------------------------------------------------------------
    logic [NEW_WIDTH-1:0] w_tok;
    logic [NEW_WIDTH-1:0] w_top;
    logic                 w_tok_is_op;
    logic [7:0]           w_tok_code;
    logic                 w_empty;
    logic                 w_top_lparen;
    logic                 w_wconst;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_discard;
    logic                 w_adv;
    logic                 w_finish;
    logic                 w_err;
    logic                 w_emit;
    logic [NEW_WIDTH-1:0] w_emit_tok;
    state_t               w_next;

    assign w_tok        = (r_i < c_DEPTH) ? infix[r_i] : '0;
    assign w_top        = (r_sp != '0) ? r_stack[r_sp - 1'b1] : '0;
    assign w_tok_is_op  = (w_tok[NEW_WIDTH-1 -: 2] != 2'b00);
    assign w_tok_code   = w_tok[7:0];
    assign w_empty      = (r_sp == '0);
    // Only operators are ever pushed, so the code alone identifies '('.
    assign w_top_lparen = !w_empty && (w_top[7:0] == c_LPAREN);
    assign w_emit       = w_wconst || w_pop;
    assign w_emit_tok   = w_pop ? w_top : w_tok;

    always_comb begin
        w_wconst  = 1'b0;
        w_pop     = 1'b0;
        w_push    = 1'b0;
        w_discard = 1'b0;
        w_adv     = 1'b0;
        w_finish  = 1'b0;
        w_err     = 1'b0;
        w_next    = r_state;
        case (r_state)
            S_SCAN: begin
                if (r_i >= infixSize) begin
                    w_next = S_FLUSH;
                end else if (!w_tok_is_op) begin
                    w_wconst = 1'b1;
                    w_adv    = 1'b1;
                end else if (f_is_func(w_tok) || w_tok_code == c_LPAREN) begin
                    w_push = 1'b1;
                    w_adv  = 1'b1;
                end else if (f_prec(w_tok) != 2'd0) begin
                    // '(' and functions have precedence 0, so they never pop here
                    if (!w_empty && f_prec(w_top) >= f_prec(w_tok)) begin
                        w_pop = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_adv  = 1'b1;
                    end
                end else if (w_tok_code == c_COMMA) begin
                    if (w_empty)           w_err = 1'b1;
                    else if (w_top_lparen) w_adv = 1'b1;
                    else                   w_pop = 1'b1;
                end else if (w_tok_code == c_RPAREN) begin
                    if (w_empty) begin
                        w_err = 1'b1;
                    end else if (w_top_lparen) begin
                        w_discard = 1'b1;
                        w_next    = S_CLOSE;
                    end else begin
                        w_pop = 1'b1;
                    end
                end else begin
                    w_err = 1'b1;
                end
            end
            S_CLOSE: begin
                if (!w_empty && f_is_func(w_top)) begin
                    w_pop = 1'b1;
                end else begin
                    w_adv  = 1'b1;
                    w_next = S_SCAN;
                end
            end
            S_FLUSH: begin
                if (w_empty)           w_finish = 1'b1;
                else if (w_top_lparen) w_err    = 1'b1;
                else                   w_pop    = 1'b1;
            end
            default: w_err = 1'b1;
        endcase
        if (w_push && r_sp == c_DEPTH) w_err = 1'b1;
        if (w_emit && r_o == c_DEPTH)  w_err = 1'b1;
    end

    // ------------------------------------------------------------------
    // State machine and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_i            <= '0;
            r_o            <= '0;
            r_sp           <= '0;
            r_postfix      <= '0;
            r_postfix_size <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            // Held high so conv asserted through reset release is not an edge
            r_conv_prev    <= 1'b1;
        end else begin
            r_conv_prev <= conv;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (conv && !r_conv_prev) begin
                        r_i            <= '0;
                        r_o            <= '0;
                        r_sp           <= '0;
                        r_postfix_size <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= (infixSize > c_DEPTH) ? S_ERR : S_SCAN;
                    end
                end
                S_ERR: begin
                    r_error        <= 1'b1;
                    r_postfix_size <= '0;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    if (w_err) begin
                        r_state <= S_ERR;
                    end else begin
                        if (w_emit) begin
                            r_postfix[r_o] <= w_emit_tok;
                            r_o            <= r_o + 1'b1;
                        end
                        if (w_push) begin
                            r_stack[r_sp] <= w_tok;
                            r_sp          <= r_sp + 1'b1;
                        end
                        if (w_pop || w_discard) begin
                            r_sp <= r_sp - 1'b1;
                        end
                        if (w_adv) begin
                            r_i <= r_i + 1'b1;
                        end
                        if (w_finish) begin
                            r_postfix_size <= r_o;
                            r_done         <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= S_IDLE;
                        end else begin
                            r_state <= w_next;
                        end
                    end
                end
            endcase
        end
    end

    assign postfixSize = r_postfix_size;
    assign postfix     = r_postfix;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_infix_to_postfix.sv
`default_nettype none
// ============================================================================
// Module      : tb_infix_to_postfix
// Description : Self-checking bench for infix_to_postfix. Expected results
//               are queued when a conversion is launched and compared when
//               the converter pulses done or error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_infix_to_postfix;

    localparam int DEPTH = 10;
    localparam int NW    = 44;
    localparam int SW    = $clog2(DEPTH + 1);

    localparam logic [7:0] c_LP  = 8'h28;
    localparam logic [7:0] c_RP  = 8'h29;
    localparam logic [7:0] c_ADD = 8'h2A;
    localparam logic [7:0] c_SUB = 8'h2B;
    localparam logic [7:0] c_MUL = 8'h2C;
    localparam logic [7:0] c_DIV = 8'h2D;
    localparam logic [7:0] c_CMA = 8'h2E;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     conv;
    logic [SW-1:0]            infix_size;
    logic [DEPTH-1:0][NW-1:0] infix;
    logic [SW-1:0]            postfix_size;
    logic [DEPTH-1:0][NW-1:0] postfix;
    logic                     busy;
    logic                     done;
    logic                     error;

    always #5 clk = ~clk;

    infix_to_postfix #(.DEPTH(DEPTH), .NEW_WIDTH(NW)) u_dut (
        .clock       (clk),
        .reset       (rst),
        .conv        (conv),
        .infixSize   (infix_size),
        .infix       (infix),
        .postfixSize (postfix_size),
        .postfix     (postfix),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    typedef struct {
        int          size;
        bit          err;
        int          lat;
        logic [NW-1:0] tok [DEPTH];
    } exp_t;

    exp_t          sb[$];
    logic [NW-1:0] in_q[$];
    logic [NW-1:0] ex_q[$];
    int            n_pass  = 0;
    int            n_total = 0;

    function automatic logic [NW-1:0] K(input int v);
        return {12'd0, 32'(v)};
    endfunction

    function automatic logic [NW-1:0] O(input logic [7:0] c);
        return {2'b01, 34'd0, c};
    endfunction

    task automatic add(input logic [NW-1:0] t);
        in_q.push_back(t);
    endtask

    task automatic exq(input logic [NW-1:0] t);
        ex_q.push_back(t);
    endtask

    // Launch one conversion from in_q, queue the expectation built from
    // ex_q, wait for the result and score it.
    task automatic run_case(input string name, input bit exp_err, input int lat,
                            input int size_override, input bit poke);
        exp_t e;
        int   cyc;
        e.size = exp_err ? 0 : ex_q.size();
        e.err  = exp_err;
        e.lat  = lat;
        for (int k = 0; k < DEPTH; k++) e.tok[k] = (k < ex_q.size()) ? ex_q[k] : '0;
        sb.push_back(e);

        infix = '0;
        for (int k = 0; k < in_q.size(); k++) infix[k] = in_q[k];
        infix_size = (size_override >= 0) ? SW'(size_override) : SW'(in_q.size());

        @(posedge clk); #1 conv = 1'b1;
        @(posedge clk); #1 conv = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b want=1", name, busy);
        else n_pass++;

        cyc = 0;
        while (!done && !error && cyc < 200) begin
            if (poke && cyc == 2) conv = 1'b1;
            if (poke && cyc == 4) conv = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        conv = 1'b0;
        e = sb.pop_front();

        n_total++;
        if ({done, error} !== {!e.err, e.err})
            $display("FAIL %s outcome got done=%b error=%b want done=%b error=%b", name, done, error, !e.err, e.err);
        else n_pass++;
        n_total++;
        if (cyc !== e.lat) $display("FAIL %s latency got=%0d want=%0d", name, cyc, e.lat);
        else n_pass++;
        n_total++;
        if (postfix_size !== SW'(e.size)) $display("FAIL %s size got=%0d want=%0d", name, postfix_size, e.size);
        else n_pass++;
        for (int k = 0; k < e.size; k++) begin
            n_total++;
            if (postfix[k] !== e.tok[k]) $display("FAIL %s token[%0d] got=%h want=%h", name, k, postfix[k], e.tok[k]);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_end got=%b want=0", name, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({done, error} !== 2'b00) $display("FAIL %s single_pulse got done=%b error=%b want 0 0", name, done, error);
        else n_pass++;
        in_q.delete();
        ex_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; conv = 1'b0; infix = '0; infix_size = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {busy, done, error});
        else n_pass++;
        n_total++;
        if (postfix_size !== '0) $display("FAIL reset_size got=%0d want=0", postfix_size);
        else n_pass++;
        n_total++;
        if (postfix !== '0) $display("FAIL reset_postfix got=%h want=0", postfix);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_precedence();
        add(K(3)); add(O(c_ADD)); add(K(4)); add(O(c_MUL)); add(K(2));
        exq(K(3)); exq(K(4)); exq(K(2)); exq(O(c_MUL)); exq(O(c_ADD));
        run_case("prec", 1'b0, 9, -1, 1'b0);
    endtask

    task automatic test_parens();
        add(O(c_LP)); add(K(1)); add(O(c_ADD)); add(K(2)); add(O(c_RP)); add(O(c_MUL)); add(K(3));
        exq(K(1)); exq(K(2)); exq(O(c_ADD)); exq(K(3)); exq(O(c_MUL));
        run_case("parens", 1'b0, 12, -1, 1'b0);
    endtask

    task automatic test_left_assoc();
        add(K(8)); add(O(c_SUB)); add(K(3)); add(O(c_SUB)); add(K(2));
        exq(K(8)); exq(K(3)); exq(O(c_SUB)); exq(K(2)); exq(O(c_SUB));
        run_case("left_assoc", 1'b0, 9, -1, 1'b0);
    endtask

    task automatic test_functions();
        add(O(8'hF2)); add(O(c_LP)); add(K(2)); add(O(c_CMA)); add(K(5)); add(O(c_RP));
        exq(K(2)); exq(K(5)); exq(O(8'hF2));
        run_case("pow", 1'b0, 10, -1, 1'b0);
        add(O(8'hF4)); add(O(c_LP)); add(K(1)); add(O(c_RP));
        exq(K(1)); exq(O(8'hF4));
        run_case("sin", 1'b0, 8, -1, 1'b0);
    endtask

    task automatic test_full_depth();
        // log(1,2) / 3 - 4 : exactly DEPTH tokens
        add(O(8'hF3)); add(O(c_LP)); add(K(1)); add(O(c_CMA)); add(K(2));
        add(O(c_RP)); add(O(c_DIV)); add(K(3)); add(O(c_SUB)); add(K(4));
        exq(K(1)); exq(K(2)); exq(O(8'hF3)); exq(K(3)); exq(O(c_DIV)); exq(K(4)); exq(O(c_SUB));
        run_case("full_depth", 1'b0, 16, -1, 1'b0);
    endtask

    task automatic test_empty();
        run_case("empty", 1'b0, 2, -1, 1'b0);
    endtask

    task automatic test_errors();
        add(O(c_LP)); add(K(1)); add(O(c_ADD)); add(K(2));
        run_case("open_paren", 1'b1, 8, -1, 1'b0);
        add(K(1)); add(O(c_RP));
        run_case("stray_close", 1'b1, 3, -1, 1'b0);
        add(O(8'h7F));
        run_case("bad_code", 1'b1, 2, -1, 1'b0);
        for (int k = 0; k < DEPTH; k++) add(K(k + 1));
        run_case("oversize", 1'b1, 1, DEPTH + 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        // conv re-asserted while busy must not disturb the conversion
        add(K(3)); add(O(c_ADD)); add(K(4)); add(O(c_MUL)); add(K(2));
        exq(K(3)); exq(K(4)); exq(K(2)); exq(O(c_MUL)); exq(O(c_ADD));
        run_case("poke_busy", 1'b0, 9, -1, 1'b1);
        add(K(8)); add(O(c_SUB)); add(K(3)); add(O(c_SUB)); add(K(2));
        exq(K(8)); exq(K(3)); exq(O(c_SUB)); exq(K(2)); exq(O(c_SUB));
        run_case("b2b", 1'b0, 9, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        infix = '0;
        infix[0] = K(3); infix[1] = O(c_ADD); infix[2] = K(4); infix[3] = O(c_MUL); infix[4] = K(2);
        infix_size = SW'(5);
        @(posedge clk); #1 conv = 1'b1;
        @(posedge clk); #1 conv = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (done || error) pulses++;
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || error) pulses++;
        end
        n_total++;
        if (pulses !== 0) $display("FAIL reset_mid_pulses got=%0d want=0", pulses);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_mid_busy got=%b want=0", busy);
        else n_pass++;
        n_total++;
        if (postfix_size !== '0) $display("FAIL reset_mid_size got=%0d want=0", postfix_size);
        else n_pass++;
        n_total++;
        if (postfix !== '0) $display("FAIL reset_mid_postfix got=%h want=0", postfix);
        else n_pass++;
    endtask

    task automatic test_conv_held();
        int starts;
        starts = 0;
        infix = '0;
        infix[0] = K(7);
        infix_size = SW'(1);
        conv = 1'b1;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy || done || error) starts++;
        end
        n_total++;
        if (starts !== 0) $display("FAIL conv_held_start got=%0d want=0", starts);
        else n_pass++;
        conv = 1'b0;
        add(O(c_LP)); add(K(1)); add(O(c_ADD)); add(K(2)); add(O(c_RP)); add(O(c_MUL)); add(K(3));
        exq(K(1)); exq(K(2)); exq(O(c_ADD)); exq(K(3)); exq(O(c_MUL));
        run_case("after_held", 1'b0, 12, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_precedence();
        test_parens();
        test_left_assoc();
        test_functions();
        test_full_depth();
        test_errors();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_conv_held();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
